// File: rtl/i2c_reg_reader.sv
`default_nettype none
// ============================================================================
// Module : i2c_reg_reader
// Sequences an I2C register burst read (START, addr+W, reg, rSTART, addr+R,
// reads, STOP) over a byte-level command/response bit engine.
// Option : define I2C_REG_READER_RETRY_EN to retry NACKed attempts (3 retries).
// Rev    : 1.0
// ============================================================================
module i2c_reg_reader #(
    parameter int MAX_LEN = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [6:0] dev_addr,
    input  logic [7:0] reg_addr,
    input  logic [3:0] rd_len,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic [2:0] cmd_op,
    output logic [7:0] cmd_data,
    input  logic       rsp_valid,
    input  logic [7:0] rsp_data,
    input  logic       rsp_nack,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       out_last,
    output logic       busy,
    output logic       done,
    output logic       err
);
    localparam logic [3:0] c_IDLE   = 4'd0;
    localparam logic [3:0] c_START1 = 4'd1;
    localparam logic [3:0] c_WADDR  = 4'd2;
    localparam logic [3:0] c_WREG   = 4'd3;
    localparam logic [3:0] c_START2 = 4'd4;
    localparam logic [3:0] c_RADDR  = 4'd5;
    localparam logic [3:0] c_READ   = 4'd6;
    localparam logic [3:0] c_STOP   = 4'd7;
    localparam logic [3:0] c_FIN    = 4'd8;

    localparam logic [2:0] c_OP_START = 3'd0;
    localparam logic [2:0] c_OP_WRITE = 3'd1;
    localparam logic [2:0] c_OP_RACK  = 3'd2;
    localparam logic [2:0] c_OP_RNACK = 3'd3;
    localparam logic [2:0] c_OP_STOP  = 3'd4;

    localparam logic [3:0] c_MAX_LEN = 4'(MAX_LEN);

    logic [3:0] r_state;
    logic       r_wait;
    logic [6:0] r_dev;
    logic [7:0] r_reg;
    logic [3:0] r_len;
    logic [3:0] r_remain;
    logic       r_cmd_valid;
    logic [2:0] r_cmd_op;
    logic [7:0] r_cmd_data;
    logic       r_out_valid;
    logic [7:0] r_out_data;
    logic       r_out_last;
    logic       r_busy;
    logic       r_done;
    logic       r_err;
`ifdef I2C_REG_READER_RETRY_EN
    logic [1:0] r_retry;
    logic       r_retrying;
`endif

    logic [3:0] w_len;
    logic [3:0] w_adv;

    // Command presented on entry to a state; remain selects ACK vs final NACK.
    function automatic logic [10:0] f_cmd(input logic [3:0] st, input logic [6:0] dev,
                                          input logic [7:0] ra, input logic [3:0] remain);
        logic [10:0] v;
        case (st)
            c_WADDR: v = {c_OP_WRITE, dev, 1'b0};
            c_WREG:  v = {c_OP_WRITE, ra};
            c_RADDR: v = {c_OP_WRITE, dev, 1'b1};
            c_READ:  v = {(remain == 4'd1) ? c_OP_RNACK : c_OP_RACK, 8'h00};
            c_STOP:  v = {c_OP_STOP, 8'h00};
            default: v = {c_OP_START, 8'h00};
        endcase
        return v;
    endfunction

    always_comb begin
        if (rd_len == 4'd0)
            w_len = 4'd1;
        else if (rd_len > c_MAX_LEN)
            w_len = c_MAX_LEN;
        else
            w_len = rd_len;
    end

    always_comb begin
        case (r_state)
            c_START1: w_adv = c_WADDR;
            c_WADDR:  w_adv = c_WREG;
            c_WREG:   w_adv = c_START2;
            c_START2: w_adv = c_RADDR;
            c_RADDR:  w_adv = c_READ;
            default:  w_adv = c_STOP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_wait      <= 1'b0;
            r_dev       <= 7'd0;
            r_reg       <= 8'd0;
            r_len       <= 4'd0;
            r_remain    <= 4'd0;
            r_cmd_valid <= 1'b0;
            r_cmd_op    <= 3'd0;
            r_cmd_data  <= 8'd0;
            r_out_valid <= 1'b0;
            r_out_data  <= 8'd0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
`ifdef I2C_REG_READER_RETRY_EN
            r_retry     <= 2'd0;
            r_retrying  <= 1'b0;
`endif
        end else begin
            r_done      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_dev       <= dev_addr;
                        r_reg       <= reg_addr;
                        r_len       <= w_len;
                        r_busy      <= 1'b1;
                        r_err       <= 1'b0;
                        r_state     <= c_START1;
                        r_cmd_valid <= 1'b1;
                        r_cmd_op    <= c_OP_START;
                        r_cmd_data  <= 8'h00;
`ifdef I2C_REG_READER_RETRY_EN
                        r_retry     <= 2'd0;
                        r_retrying  <= 1'b0;
`endif
                    end
                end
                c_FIN: begin
                    r_state <= c_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    if (r_cmd_valid) begin
                        if (cmd_ready) begin
                            if (r_state == c_START1 || r_state == c_START2) begin
                                r_state                <= w_adv;
                                {r_cmd_op, r_cmd_data} <= f_cmd(w_adv, r_dev, r_reg, r_len);
                            end else if (r_state == c_STOP) begin
`ifdef I2C_REG_READER_RETRY_EN
                                if (r_retrying) begin
                                    r_retrying <= 1'b0;
                                    r_state    <= c_START1;
                                    r_cmd_op   <= c_OP_START;
                                    r_cmd_data <= 8'h00;
                                end else begin
                                    r_cmd_valid <= 1'b0;
                                    r_cmd_op    <= 3'd0;
                                    r_cmd_data  <= 8'd0;
                                    r_state     <= c_FIN;
                                    r_done      <= 1'b1;
                                end
`else
                                r_cmd_valid <= 1'b0;
                                r_cmd_op    <= 3'd0;
                                r_cmd_data  <= 8'd0;
                                r_state     <= c_FIN;
                                r_done      <= 1'b1;
`endif
                            end else begin
                                r_cmd_valid <= 1'b0;
                                r_cmd_op    <= 3'd0;
                                r_cmd_data  <= 8'd0;
                                r_wait      <= 1'b1;
                            end
                        end
                    end else if (r_wait && rsp_valid) begin
                        r_wait      <= 1'b0;
                        r_cmd_valid <= 1'b1;
                        if (r_state == c_READ) begin
                            r_out_valid <= 1'b1;
                            r_out_data  <= rsp_data;
                            r_out_last  <= (r_remain == 4'd1);
                            if (r_remain == 4'd1) begin
                                r_state    <= c_STOP;
                                r_cmd_op   <= c_OP_STOP;
                                r_cmd_data <= 8'h00;
                            end else begin
                                r_remain               <= r_remain - 4'd1;
                                {r_cmd_op, r_cmd_data} <= f_cmd(c_READ, r_dev, r_reg, r_remain - 4'd1);
                            end
                        end else if (rsp_nack) begin
`ifdef I2C_REG_READER_RETRY_EN
                            if (r_retry == 2'd3) begin
                                r_err <= 1'b1;
                            end else begin
                                r_retry    <= r_retry + 2'd1;
                                r_retrying <= 1'b1;
                            end
`else
                            r_err <= 1'b1;
`endif
                            r_state    <= c_STOP;
                            r_cmd_op   <= c_OP_STOP;
                            r_cmd_data <= 8'h00;
                        end else begin
                            r_state                <= w_adv;
                            {r_cmd_op, r_cmd_data} <= f_cmd(w_adv, r_dev, r_reg, r_len);
                            if (w_adv == c_READ)
                                r_remain <= r_len;
                        end
                    end
                end
            endcase
        end
    end

    assign cmd_valid = r_cmd_valid;
    assign cmd_op    = r_cmd_op;
    assign cmd_data  = r_cmd_data;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_i2c_reg_reader.sv
`default_nettype none
// ============================================================================
// Module : tb_i2c_reg_reader
// Self-checking bench: acts as the I2C bit engine and checks the command
// stream, read bytes and status against a transaction-level model.
// Rev    : 1.0
// ============================================================================
module tb_i2c_reg_reader;
    localparam int MAX_LEN = 8;
`ifdef I2C_REG_READER_RETRY_EN
    localparam int RETRIES = 3;
`else
    localparam int RETRIES = 0;
`endif
    localparam logic [2:0] OP_START = 3'd0;
    localparam logic [2:0] OP_W     = 3'd1;
    localparam logic [2:0] OP_RACK  = 3'd2;
    localparam logic [2:0] OP_RNACK = 3'd3;
    localparam logic [2:0] OP_STOP  = 3'd4;

    logic       clk = 1'b0;
    logic       rst, start, cmd_ready, rsp_valid, rsp_nack;
    logic [6:0] dev_addr;
    logic [7:0] reg_addr, rsp_data;
    logic [3:0] rd_len;
    logic       cmd_valid, out_valid, out_last, busy, done, err;
    logic [2:0] cmd_op;
    logic [7:0] cmd_data, out_data;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    i2c_reg_reader #(.MAX_LEN(MAX_LEN)) dut (
        .clk(clk), .rst(rst), .start(start), .dev_addr(dev_addr), .reg_addr(reg_addr),
        .rd_len(rd_len), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_nack(rsp_nack),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
        .busy(busy), .done(done), .err(err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One transaction; nack_idx 0..2 NACKs that write of every attempt, 3 = none.
    task automatic run_txn(input logic [6:0] dev, input logic [7:0] ra, input logic [3:0] len,
                           input int nack_idx, input int ready_pct, input bit rst_in_read);
        logic [10:0] expq[$];
        logic [8:0]  outq[$];
        logic [10:0] e, prev_cmd;
        logic [8:0]  o;
        logic [7:0]  rd;
        int L, n_att, w_in_att, pend, reads_done, hold, cyc;
        bit exp_err, awaiting, pend_read, cur_nack, exp_out, exp_done;
        bit prev_pend, prev_ss, finished, hold_used, xfer, aborted;

        L = (len == 4'd0) ? 1 : ((int'(len) > MAX_LEN) ? MAX_LEN : int'(len));
        exp_err = (nack_idx < 3);
        n_att = exp_err ? RETRIES + 1 : 1;
        for (int a = 0; a < n_att; a++) begin
            expq.push_back({OP_START, 8'h00});
            expq.push_back({OP_W, dev, 1'b0});
            if (nack_idx == 0) begin expq.push_back({OP_STOP, 8'h00}); continue; end
            expq.push_back({OP_W, ra});
            if (nack_idx == 1) begin expq.push_back({OP_STOP, 8'h00}); continue; end
            expq.push_back({OP_START, 8'h00});
            expq.push_back({OP_W, dev, 1'b1});
            if (nack_idx == 2) begin expq.push_back({OP_STOP, 8'h00}); continue; end
            for (int i = 0; i < L; i++)
                expq.push_back({(i == L - 1) ? OP_RNACK : OP_RACK, 8'h00});
            expq.push_back({OP_STOP, 8'h00});
        end

        w_in_att = 0; pend = 0; reads_done = 0; hold = 0; cyc = 0;
        awaiting = 0; pend_read = 0; cur_nack = 0; exp_out = 0; exp_done = 0;
        prev_pend = 0; prev_ss = 0; finished = 0; hold_used = 0; aborted = 0;
        prev_cmd = '0;

        @(negedge clk);
        dev_addr = dev; reg_addr = ra; rd_len = len; start = 1'b1;
        cmd_ready = 1'b0; rsp_valid = 1'b0;

        while (!finished && !aborted && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1)
                chk("start_accept", {busy, cmd_valid, cmd_op, err}, {1'b1, 1'b1, OP_START, 1'b0});
            chk("out_valid", out_valid, exp_out);
            if (exp_out) begin
                o = outq.pop_front();
                chk("out_byte", {out_last, out_data}, o);
            end
            exp_out = 0;
            chk("done", done, exp_done);
            chk("busy", busy, 1);
            if (awaiting) chk("valid_in_wait", cmd_valid, 0);
            if (prev_ss) chk("b2b_cmd", cmd_valid, 1);
            if (prev_pend) chk("cmd_stable", {cmd_valid, cmd_op, cmd_data}, {1'b1, prev_cmd});

            if (rst_in_read && cmd_valid && (cmd_op == OP_RACK || cmd_op == OP_RNACK)) begin
                rst = 1'b1; start = 1'b0; cmd_ready = 1'b0; rsp_valid = 1'b0;
                @(negedge clk);
                chk("rst_outputs", {cmd_valid, cmd_op, cmd_data, out_valid, out_data,
                                    out_last, busy, done, err}, 0);
                rst = 1'b0;
                aborted = 1;
            end else if (exp_done) begin
                finished = 1;
                start = 1'b1;
                cmd_ready = 1'($urandom);
                rsp_valid = 1'b0;
            end else begin
                start = ($urandom_range(3) == 0);
                dev_addr = 7'($urandom); reg_addr = 8'($urandom); rd_len = 4'($urandom);
                rsp_valid = 1'b0; rsp_data = 8'($urandom); rsp_nack = 1'($urandom);
                if (awaiting) begin
                    pend--;
                    if (pend == 0) begin
                        awaiting = 0;
                        rsp_valid = 1'b1;
                        if (pend_read) begin
                            rd = 8'($urandom);
                            rsp_data = rd;
                            reads_done++;
                            outq.push_back({reads_done == L, rd});
                            exp_out = 1;
                        end else begin
                            rsp_nack = cur_nack;
                        end
                    end
                end else if ($urandom_range(7) == 0) begin
                    rsp_valid = 1'b1;
                end

                if (hold > 0) begin
                    cmd_ready = 1'b0; hold--;
                end else if (cmd_valid && !hold_used && cmd_op == OP_W && w_in_att == 1) begin
                    hold_used = 1; hold = 4; cmd_ready = 1'b0;
                end else begin
                    cmd_ready = (int'($urandom_range(99)) < ready_pct);
                end

                xfer = cmd_valid && cmd_ready;
                prev_pend = cmd_valid && !xfer;
                prev_cmd = {cmd_op, cmd_data};
                prev_ss = 0;
                if (xfer) begin
                    e = (expq.size() == 0) ? 11'h7FF : expq.pop_front();
                    chk("cmd_seq", {cmd_op, cmd_data}, e);
                    case (e[10:8])
                        OP_START: prev_ss = 1;
                        OP_W: begin
                            awaiting = 1; pend = int'($urandom_range(1, 3)); pend_read = 0;
                            cur_nack = (w_in_att == nack_idx);
                            w_in_att++;
                        end
                        OP_RACK, OP_RNACK: begin
                            awaiting = 1; pend = int'($urandom_range(1, 3)); pend_read = 1;
                        end
                        OP_STOP: begin
                            w_in_att = 0;
                            if (expq.size() == 0) exp_done = 1;
                            else prev_ss = 1;
                        end
                        default: ;
                    endcase
                end
            end
        end

        if (rst_in_read) begin
            chk("rst_reached", aborted, 1);
        end else begin
            chk("finished", finished, 1);
            @(negedge clk);
            start = 1'b0;
            chk("idle_after_done", {busy, cmd_valid, done}, 0);
            chk("err_final", err, exp_err);
            chk("cmd_left", expq.size(), 0);
            chk("out_left", outq.size(), 0);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_nack = 1'b0;
        rsp_data = 8'h00; dev_addr = 7'h00; reg_addr = 8'h00; rd_len = 4'h0;
        repeat (3) @(negedge clk);
        chk("reset_state", {cmd_valid, cmd_op, cmd_data, out_valid, out_data,
                            out_last, busy, done, err}, 0);
        rst = 1'b0;

        run_txn(7'h76, 8'hD0, 4'd1, 3, 100, 1'b0);
        run_txn(7'h76, 8'hD0, 4'd3, 3, 100, 1'b0);
        run_txn(7'h76, 8'hD0, 4'd1, 0, 100, 1'b0);
        run_txn(7'h76, 8'hD0, 4'd2, 1, 70, 1'b0);
        run_txn(7'h76, 8'hD0, 4'd2, 2, 70, 1'b0);
        run_txn(7'h76, 8'hD0, 4'd0, 3, 100, 1'b0);
        run_txn(7'h76, 8'hD0, 4'd15, 3, 100, 1'b0);
        run_txn(7'h76, 8'hD0, 4'd4, 3, 100, 1'b1);
        run_txn(7'h76, 8'hD0, 4'd2, 3, 100, 1'b0);
        for (int t = 0; t < 20; t++) begin
            run_txn(7'($urandom), 8'($urandom), 4'($urandom),
                    ($urandom_range(3) == 0) ? int'($urandom_range(2)) : 3,
                    int'($urandom_range(30, 100)), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/i2c_reg_reader.md
I2C_REG_READER -- requirements
Module: i2c_reg_reader

Interface
REQ-001 SHALL have parameter MAX_LEN, default 8, maximum read burst length in bytes (1..15).
REQ-002 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start  input  1  request pulse; sampled only in IDLE.
REQ-005 SHALL have port dev_addr  input  7  target 7-bit address, e.g. 7'h76; captured on accepted start.
REQ-006 SHALL have port reg_addr  input  8  first register to read; captured on accepted start.
REQ-007 SHALL have port rd_len  input  4  byte count; captured on accepted start.
REQ-008 SHALL have ports cmd_valid output 1, cmd_ready input 1, cmd_op output 3, cmd_data output 8: command channel to the downstream I2C bit engine.
REQ-009 SHALL have ports rsp_valid input 1, rsp_data input 8, rsp_nack input 1: one-cycle response from the bit engine after each WRITE or READ command.
REQ-010 SHALL have ports out_valid output 1, out_data output 8, out_last output 1: read-byte stream.
REQ-011 SHALL have ports busy output 1, done output 1, err output 1: status.

Function
REQ-012 cmd_op encoding SHALL be 0 START, 1 WRITE, 2 READ_ACK, 3 READ_NACK, 4 STOP; cmd_data is meaningful only for WRITE and SHALL be 0 otherwise.
REQ-013 A command SHALL transfer on a cycle with cmd_valid and cmd_ready both high; cmd_op/cmd_data SHALL be stable while cmd_valid is high and not accepted.
REQ-014 After a WRITE/READ transfer cmd_valid SHALL stay low until rsp_valid; after START/STOP the next command SHALL be presented the cycle following transfer.
REQ-015 States SHALL be IDLE, START1, WADDR, WREG, START2, RADDR, READ, STOP, FIN; sequence START, WRITE {dev_addr,0}, WRITE reg_addr, START, WRITE {dev_addr,1}, rd_len reads, STOP.
REQ-016 Each read except the last SHALL use READ_ACK; the last SHALL use READ_NACK.
REQ-017 start high in IDLE SHALL raise busy and cmd_valid (op START) on the next cycle; start while busy SHALL be ignored.
REQ-018 rd_len 0 SHALL be treated as 1; rd_len > MAX_LEN SHALL be clamped to MAX_LEN.
REQ-019 Each read response SHALL produce out_valid for exactly one cycle, one cycle after rsp_valid, with out_data = rsp_data; out_last SHALL be high with the final byte only.
REQ-020 rsp_nack high on any WRITE response SHALL abort to STOP (no further writes/reads), set err, and emit no out_valid.
REQ-021 rsp_nack SHALL be ignored on READ responses; rsp_valid outside a wait state SHALL be ignored.
REQ-022 FIN SHALL pulse done for one cycle the cycle after STOP transfers, then return to IDLE with busy low; a start on that done cycle SHALL be ignored.
REQ-023 err SHALL hold until the next accepted start, which clears it.

Reset
REQ-024 rst SHALL force IDLE; cmd_valid, cmd_op, cmd_data, out_valid, out_data, out_last, busy, done, err all 0 on the following edge.
REQ-025 rst mid-transaction SHALL abort without issuing STOP; rst SHALL take priority over start and all handshakes.

Configuration
REQ-026 With macro I2C_REG_READER_RETRY_EN defined, a NACK SHALL issue STOP and restart from START1 up to 3 retries, setting err only after the fourth NACK; retries SHALL keep busy high, with no done pulse between attempts.
REQ-027 Without I2C_REG_READER_RETRY_EN, the first NACK SHALL behave per REQ-020.

Verification
REQ-028 dev 0x76, reg 0xD0, len 1, cmd_ready=1, rsp_data 0x60 -> ops START, WRITE 0xEC, WRITE 0xD0, START, WRITE 0xED, READ_NACK, STOP; out_data 0x60, out_last 1, done pulse, err 0.
REQ-029 len 3, reads 0x11,0x22,0x33 -> READ_ACK, READ_ACK, READ_NACK; three out_valid pulses, out_last only on 0x33.
REQ-030 rsp_nack=1 on WRITE 0xEC -> next op STOP, err 1, no out_valid, done pulse; with RETRY_EN and NACK persisting: 4 attempts, then err 1.
REQ-031 cmd_ready held low 5 cycles on WRITE 0xD0 -> cmd_op/cmd_data stable all 5 cycles, single transfer.
REQ-032 rst asserted while in READ -> next cycle all outputs 0, IDLE; new start then runs a clean sequence.
REQ-033 rd_len 0 -> one READ_NACK; rd_len 15 with MAX_LEN 8 -> 7 READ_ACK + 1 READ_NACK.
